// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one imem read per PC, steers the PC register, and holds the fetched word in IF/ID.
// Optional FETCH_PERF_EN adds fetch_count_o, a wrapping count of accepted instructions.
module instr_fetch_unit #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_STEP = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_i,
  output logic               pc_enable_o,
  output logic [PC_W-1:0]    next_pc_o,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [PC_W-1:0]    id_pc_plus_o
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count_o
`endif
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [PC_W-1:0]    id_pc_plus_q, id_pc_plus_d;
  logic               buf_free;
  logic               accept;
  logic [PC_W-1:0]    acc_addr;

  assign buf_free = !id_valid_q || id_ready_i;

  // Next-state, memory request and PC steering
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_i;
    pc_enable_o = 1'b0;
    next_pc_o   = pc_i + STEP;
    accept      = 1'b0;
    acc_addr    = req_addr_q;

    case (state_q)
      IDLE: begin
        if (buf_free && !redirect_i) begin
          imem_req_o = 1'b1;
          req_addr_d = pc_i;
          acc_addr   = pc_i;
          if (imem_ack_i) accept = 1'b1;
          else            state_d = WAIT;
        end
      end
      WAIT: begin
        imem_req_o  = 1'b1;
        imem_addr_o = req_addr_q;
        if (imem_ack_i) begin
          state_d = IDLE;
          accept  = !redirect_i;
        end else if (redirect_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = req_addr_q;
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      pc_enable_o = 1'b1;
      next_pc_o   = acc_addr + STEP;
    end
    if (redirect_i) begin
      pc_enable_o = 1'b1;
      next_pc_o   = redirect_pc_i;
    end
    // Strobes stay quiet while reset is held so a stale PC is never loaded
    if (reset) begin
      imem_req_o  = 1'b0;
      pc_enable_o = 1'b0;
    end
  end

  // IF/ID register next state: flush beats accept beats consume
  always_comb begin
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc_plus_d = id_pc_plus_q;
    if (redirect_i) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d   = 1'b1;
      id_instr_d   = imem_rdata_i;
      id_pc_d      = acc_addr;
      id_pc_plus_d = acc_addr + STEP;
    end else if (id_valid_q && id_ready_i) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      id_pc_plus_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc_plus_q <= id_pc_plus_d;
    end
  end

  assign id_valid_o   = id_valid_q;
  assign id_instr_o   = id_instr_q;
  assign id_pc_o      = id_pc_q;
  assign id_pc_plus_o = id_pc_plus_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       fetch_count_q <= '0;
    else if (accept) fetch_count_q <= fetch_count_q + 16'd1;
  end

  assign fetch_count_o = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a PC register model and a latency-programmable memory.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_enable;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pc_plus;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat     = 0;
  int   lat_cnt;

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .pc_i         (pc),
    .pc_enable_o  (pc_enable),
    .next_pc_o    (next_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_valid_o   (id_valid),
    .id_ready_i   (id_ready),
    .id_instr_o   (id_instr),
    .id_pc_o      (id_pc),
    .id_pc_plus_o (id_pc_plus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count_o(fetch_count)
`endif
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic exp_t mk(input logic [15:0] a);
    mk.pc      = a;
    mk.instr   = word_at(a);
    mk.pc_plus = a + 16'd2;
  endfunction

  // PC register and memory model
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          pc <= 16'h0000;
    else if (pc_enable) pc <= next_pc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      lat_cnt <= 0;
    else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 1;
    else                            lat_cnt <= 0;
  end

  assign imem_ack   = imem_req && (lat_cnt >= lat);
  assign imem_rdata = word_at(imem_addr);

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy, input logic rd, input logic [15:0] rpc);
    reset = 1'b1; lat = l; id_ready = rdy; redirect = rd; redirect_pc = rpc;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; lat = 0;
    cyc();
    @(negedge clock);
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h want 0", id_valid); end
    n_tests++; if (id_instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", id_instr); end
    n_tests++; if (id_pc !== 16'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", id_pc); end
    n_tests++; if (id_pc_plus !== 16'h0) begin n_fail++; $display("FAIL rst_pc_plus got %h want 0", id_pc_plus); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %h want 0", imem_req); end
    n_tests++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en got %h want 0", pc_enable); end
  endtask

  task automatic test_back_to_back();
    do_reset(0, 1'b1, 1'b0, 16'h0);
    exp_q.push_back(mk(16'h0000)); exp_q.push_back(mk(16'h0002)); exp_q.push_back(mk(16'h0004));
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      n_tests++; if (pc_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_pc_en[%0d] got %h want 1", n, pc_enable); end
      n_tests++; if (imem_addr !== 16'(2 * n)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h want %h", n, imem_addr, 16'(2 * n)); end
      if (n >= 1) begin
        n_tests++;
        if (id_valid !== 1'b1 || exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_valid[%0d] got %h want 1 (queue %0d)", n, id_valid, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (id_pc !== e.pc || id_instr !== e.instr) begin
            n_fail++; $display("FAIL b2b_data[%0d] got %h/%h want %h/%h", n, id_pc, id_instr, e.pc, e.instr);
          end
        end
      end
`ifdef FETCH_PERF_EN
      if (n == 3) begin
        n_tests++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", fetch_count); end
      end
`endif
      cyc();
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_q.push_back(mk(16'h0006));
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      n_tests++; if (id_valid !== 1'b1 || id_pc !== 16'h0006 || id_instr !== word_at(16'h0006)) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%h pc=%h instr=%h want v=1 pc=0006", n, id_valid, id_pc, id_instr); end
      n_tests++; if (imem_req !== 1'b0 || pc_enable !== 1'b0) begin
        n_fail++; $display("FAIL bp_quiet[%0d] got req=%h pc_en=%h want 0/0", n, imem_req, pc_enable); end
      cyc();
    end
    id_ready = 1'b1;
    exp_q.push_back(mk(16'h0008));
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc) begin n_fail++; $display("FAIL bp_release got %h want %h", id_pc, e.pc); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008 || pc_enable !== 1'b1) begin
      n_fail++; $display("FAIL bp_resume got req=%h addr=%h pc_en=%h want 1/0008/1", imem_req, imem_addr, pc_enable); end
    cyc();
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_instr !== e.instr) begin
      n_fail++; $display("FAIL bp_next got %h/%h want %h/%h", id_pc, id_instr, e.pc, e.instr); end
  endtask

  task automatic test_latency();
    do_reset(2, 1'b0, 1'b0, 16'h0);
    exp_q.push_back(mk(16'h0000));
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
        n_fail++; $display("FAIL lat_req[%0d] got req=%h addr=%h want 1/0000", n, imem_req, imem_addr); end
      n_tests++; if (pc_enable !== (n == 2)) begin n_fail++; $display("FAIL lat_pc_en[%0d] got %h want %h", n, pc_enable, (n == 2)); end
      n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid[%0d] got %h want 0", n, id_valid); end
      cyc();
    end
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_instr !== e.instr || id_pc_plus !== e.pc_plus) begin
      n_fail++; $display("FAIL lat_data got v=%h %h/%h/%h want 1 %h/%h/%h", id_valid, id_pc, id_instr, id_pc_plus, e.pc, e.instr, e.pc_plus); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL lat_stall_req got %h want 0", imem_req); end
  endtask

  task automatic test_redirect_drain();
    do_reset(3, 1'b0, 1'b1, 16'h0010);
    @(negedge clock);
    n_tests++; if (pc_enable !== 1'b1 || next_pc !== 16'h0010 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL drn_idle_redir got pc_en=%h next=%h req=%h want 1/0010/0", pc_enable, next_pc, imem_req); end
    cyc(); redirect = 1'b0;
    @(negedge clock);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      n_fail++; $display("FAIL drn_issue got req=%h addr=%h want 1/0010", imem_req, imem_addr); end
    cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clock);
    n_tests++; if (pc_enable !== 1'b1 || next_pc !== 16'h0100) begin
      n_fail++; $display("FAIL drn_redir got pc_en=%h next=%h want 1/0100", pc_enable, next_pc); end
    cyc(); redirect = 1'b0;
    @(negedge clock);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL drn_hold got req=%h addr=%h v=%h want 1/0010/0", imem_req, imem_addr, id_valid); end
    cyc();
    @(negedge clock);
    n_tests++; if (pc_enable !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL drn_stale got pc_en=%h v=%h want 0/0", pc_enable, id_valid); end
    cyc(); lat = 0;
    exp_q.push_back(mk(16'h0100));
    @(negedge clock);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL drn_refetch got req=%h addr=%h v=%h want 1/0100/0", imem_req, imem_addr, id_valid); end
    cyc();
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_instr !== e.instr) begin
      n_fail++; $display("FAIL drn_data got v=%h %h/%h want 1 %h/%h", id_valid, id_pc, id_instr, e.pc, e.instr); end
`ifdef FETCH_PERF_EN
    n_tests++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL drn_count got %0d want 1", fetch_count); end
`endif
  endtask

  task automatic test_redirect_ack();
    do_reset(2, 1'b0, 1'b1, 16'h0010);
    cyc(); redirect = 1'b0;
    cyc();
    cyc(); redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clock);
    n_tests++; if (imem_ack !== 1'b1 || imem_addr !== 16'h0010 || pc_enable !== 1'b1 || next_pc !== 16'h0100) begin
      n_fail++; $display("FAIL rack_redir got ack=%h addr=%h pc_en=%h next=%h want 1/0010/1/0100", imem_ack, imem_addr, pc_enable, next_pc); end
    cyc(); redirect = 1'b0; lat = 0;
    exp_q.push_back(mk(16'h0100));
    @(negedge clock);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rack_nodrain got req=%h addr=%h v=%h want 1/0100/0", imem_req, imem_addr, id_valid); end
    cyc();
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_instr !== e.instr) begin
      n_fail++; $display("FAIL rack_data got v=%h %h/%h want 1 %h/%h", id_valid, id_pc, id_instr, e.pc, e.instr); end
`ifdef FETCH_PERF_EN
    n_tests++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL rack_count got %0d want 1", fetch_count); end
`endif
  endtask

  task automatic test_wrap_and_reset();
    do_reset(0, 1'b0, 1'b1, 16'hFFFE);
    cyc(); redirect = 1'b0;
    exp_q.push_back(mk(16'hFFFE));
    @(negedge clock);
    n_tests++; if (imem_addr !== 16'hFFFE || pc_enable !== 1'b1 || next_pc !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_next got addr=%h pc_en=%h next=%h want FFFE/1/0000", imem_addr, pc_enable, next_pc); end
    cyc(); id_ready = 1'b1; lat = 5;
    @(negedge clock);
    e = exp_q.pop_front();
    n_tests++; if (id_valid !== 1'b1 || id_pc !== e.pc || id_pc_plus !== e.pc_plus || id_instr !== e.instr) begin
      n_fail++; $display("FAIL wrap_data got v=%h %h/%h/%h want 1 %h/%h/%h", id_valid, id_pc, id_pc_plus, id_instr, e.pc, e.pc_plus, e.instr); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_fetch got req=%h addr=%h want 1/0000", imem_req, imem_addr); end
    cyc(); reset = 1'b1;
    #1;
    @(negedge clock);
    n_tests++; if (imem_req !== 1'b0 || pc_enable !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_rst_ctl got req=%h pc_en=%h v=%h want 0/0/0", imem_req, pc_enable, id_valid); end
    n_tests++; if (id_pc !== 16'h0 || id_instr !== 16'h0 || id_pc_plus !== 16'h0) begin
      n_fail++; $display("FAIL wait_rst_data got %h/%h/%h want 0/0/0", id_pc, id_instr, id_pc_plus); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_latency();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
